reel_spin_controller: RTL and testbench
=======================================

# reel_spin_controller

Parametrised multi-reel spin controller for the slot-machine datapath. It drives NUM_REELS free-running symbol counters and shows them live on the reel outputs while a spin is active. Each debounced stop-button press freezes the next reel, starting at the most-significant reel. After the last reel stops, it reports completion with a one-cycle done pulse and registered match flags, which feed the hex display decoders and the payout logic downstream.

## Interface
- NUM_REELS, 3, number of reels (1–8)
- DIGIT_W, 4, bits per reel symbol
- SYMBOLS, 16, reel modulus; even, 2 ≤ SYMBOLS ≤ 2^DIGIT_W
- PRESCALE, 1, clock cycles between reel-counter advances (≥1)
- DEBOUNCE, 16, consecutive stable cycles required to accept a button level change (≥1)
- CLOCK_50  in  1  system clock; everything is synchronous to its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  synchronous pulse; begins a spin when in IDLE
- stop_key  in  1  raw push-button, active-low, asynchronous to the clock
- spin_value  out  NUM_REELS*DIGIT_W  reel fields; reel i occupies bits [i*DIGIT_W +: DIGIT_W]; reel NUM_REELS-1 is the leftmost display digit
- reel_stopped  out  NUM_REELS  bit i is set once reel i is frozen
- busy  out  1  high in SPIN and RESULT
- done  out  1  one-cycle pulse in RESULT
- all_match  out  1  all reels equal; registered in RESULT
- pair_match  out  1  at least two reels equal; registered in RESULT

## Operation
- Reel counters: NUM_REELS registers of DIGIT_W bits, reset to 0, free-running in every state.
  - A shared prescaler counts 0..PRESCALE-1 and asserts adv on its terminal count.
  - On adv, counter i ← (counter i + 2i+1) mod SYMBOLS.
  - Because the step is odd and SYMBOLS is even-or-power-of-2 per the parameter rules, each reel visits all SYMBOLS values for power-of-2 SYMBOLS.
- Button conditioning:
  - stop_key passes through a 2-FF synchroniser.
  - A debounce counter updates the debounced level (reset value 1) only after the synchronised value has differed from it for DEBOUNCE consecutive cycles. Any bounce restarts the count.
  - stop_evt is a one-cycle pulse on a debounced 1→0 transition. Release generates no event.
- FSM states: IDLE, SPIN, RESULT. Reset state is IDLE.
- IDLE:
  - spin_value, reel_stopped and the match flags hold their last values.
  - stop_evt is ignored.
  - start → SPIN. On this transition, reel_stopped, all_match and pair_match clear, and stop pointer p ← NUM_REELS-1.
- SPIN:
  - Every field i with reel_stopped[i]=0 is loaded each cycle with counter i, so the display tracks the counters live.
  - On stop_evt, field p freezes at the counter value present in that cycle (the pre-advance value), reel_stopped[p] is set, and p is decremented.
  - When p=0 is stopped → RESULT.
  - start is ignored in SPIN.
- RESULT (exactly one cycle):
  - done=1.
  - all_match and pair_match are registered from the frozen fields.
  - Then → IDLE.
  - stop_evt and start are ignored in RESULT.
- Reset mid-operation: all outputs, counters, debounce state and pointer return to reset values immediately. Any partial spin is discarded.

## Timing
- Reset values: spin_value=0, reel_stopped=0, busy=0, done=0, all_match=0, pair_match=0.
- start sampled in IDLE at edge k: busy=1 and fields live from edge k+1.
- Raw press held stable from cycle t: stop_evt occurs in cycle t+2+DEBOUNCE. The reel freezes at that edge, and reel_stopped updates on the same edge.
- After the last stop_evt edge, done is high for exactly the next cycle and busy falls with done.
- Match flags are valid the same cycle done is high. They stay stable until the next accepted start.
- A stop_evt coinciding with adv latches the pre-advance counter value.

## Test plan
- Reset with NUM_REELS=3, PRESCALE=1, DEBOUNCE=4 → all outputs 0. After 3 cycles the counters are 3, 9, 15 (mod 16) for reels 0, 1, 2.
- start at cycle 10, then a clean press → stop_evt at press+6. reel_stopped goes 100→110→111 over three presses. done pulses once and busy drops the same cycle.
- Bouncing stop_key (toggle every 2 cycles for 20 cycles, then low) → exactly one stop_evt, 6 cycles after the final settle.
- PRESCALE chosen so all reels read 0x7 when stopped (force counters via stop timing) → all_match=1, pair_match=1. With values 7, 7, 2 → all_match=0, pair_match=1.
- start pulsed during SPIN and during RESULT → ignored. Press in IDLE → no field changes.
- reset asserted after the second stop → all outputs 0 asynchronously. A fresh start runs a full three-stop spin correctly.

Source files
------------

// File: rtl/reel_spin_controller.sv
// Multi-reel spin controller: free-running reel counters, debounced stop button,
// sequential reel freezing from the leftmost reel, and registered match flags.
module reel_spin_controller #(
    parameter int NUM_REELS = 3,
    parameter int DIGIT_W   = 4,
    parameter int SYMBOLS   = 16,
    parameter int PRESCALE  = 1,
    parameter int DEBOUNCE  = 16
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop_key,
    output logic [NUM_REELS*DIGIT_W-1:0]   spin_value,
    output logic [NUM_REELS-1:0]           reel_stopped,
    output logic                           busy,
    output logic                           done,
    output logic                           all_match,
    output logic                           pair_match
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int PTR_W = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPIN   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // ---------------- prescaler and reel counters ----------------
    logic [PS_W-1:0]              pre_reg;
    logic                         adv;
    logic [NUM_REELS*DIGIT_W-1:0] cnt_flat;

    assign adv = (pre_reg == PS_W'(PRESCALE - 1));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            pre_reg <= '0;
        else if (adv)
            pre_reg <= '0;
        else
            pre_reg <= pre_reg + PS_W'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REELS; gi++) begin : g_reel
            // Step reduced modulo SYMBOLS so a single conditional subtract wraps it
            localparam int STEP = (2 * gi + 1) % SYMBOLS;
            logic [DIGIT_W-1:0] cnt_reg;
            logic [DIGIT_W:0]   sum;

            assign sum = {1'b0, cnt_reg} + (DIGIT_W + 1)'(STEP);

            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset)
                    cnt_reg <= '0;
                else if (adv)
                    cnt_reg <= (sum >= (DIGIT_W + 1)'(SYMBOLS))
                               ? DIGIT_W'(sum - (DIGIT_W + 1)'(SYMBOLS))
                               : sum[DIGIT_W-1:0];
            end

            assign cnt_flat[gi*DIGIT_W +: DIGIT_W] = cnt_reg;
        end
    endgenerate

    // ---------------- stop button conditioning ----------------
    logic            sync1_reg, sync2_reg, deb_reg, stop_evt_reg;
    logic [DB_W-1:0] db_cnt_reg;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            deb_reg      <= 1'b1;
            db_cnt_reg   <= '0;
            stop_evt_reg <= 1'b0;
        end else begin
            sync1_reg    <= stop_key;
            sync2_reg    <= sync1_reg;
            stop_evt_reg <= 1'b0;
            if (sync2_reg == deb_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_W'(DEBOUNCE - 1)) begin
                deb_reg      <= sync2_reg;
                db_cnt_reg   <= '0;
                stop_evt_reg <= ~sync2_reg;
            end else begin
                db_cnt_reg <= db_cnt_reg + DB_W'(1);
            end
        end
    end

    // ---------------- control FSM ----------------
    logic spin_start, stop_now, last_stop;
    logic [PTR_W-1:0] ptr_reg, ptr_next;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        spin_start = 1'b0;
        stop_now   = 1'b0;
        last_stop  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SPIN;
                    spin_start = 1'b1;
                end
            end
            SPIN: begin
                busy = 1'b1;
                if (stop_evt_reg) begin
                    stop_now = 1'b1;
                    if (ptr_reg == '0) begin
                        last_stop  = 1'b1;
                        state_next = RESULT;
                    end
                end
            end
            RESULT: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- reel fields and match flags ----------------
    logic [NUM_REELS*DIGIT_W-1:0] field_reg, field_next;
    logic [NUM_REELS-1:0]         stopped_reg, stopped_next;
    logic                         all_reg, pair_reg, all_next, pair_next;
    logic [DIGIT_W-1:0]           fld [NUM_REELS];

    // A stopping reel is still loaded this cycle, which captures the pre-advance value
    always_comb begin
        field_next   = field_reg;
        stopped_next = stopped_reg;
        ptr_next     = ptr_reg;
        if (spin_start) begin
            stopped_next = '0;
            ptr_next     = PTR_W'(NUM_REELS - 1);
        end
        if (state_reg == SPIN) begin
            for (int i = 0; i < NUM_REELS; i++) begin
                if (!stopped_reg[i])
                    field_next[i*DIGIT_W +: DIGIT_W] = cnt_flat[i*DIGIT_W +: DIGIT_W];
            end
            if (stop_now) begin
                stopped_next[ptr_reg] = 1'b1;
                ptr_next              = ptr_reg - PTR_W'(1);
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REELS; gi++) begin : g_fld
            assign fld[gi] = field_next[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    always_comb begin
        all_next  = 1'b1;
        pair_next = 1'b0;
        for (int i = 0; i < NUM_REELS; i++) begin
            if (fld[i] != fld[0])
                all_next = 1'b0;
            for (int j = i + 1; j < NUM_REELS; j++) begin
                if (fld[i] == fld[j])
                    pair_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            field_reg   <= '0;
            stopped_reg <= '0;
            ptr_reg     <= '0;
            all_reg     <= 1'b0;
            pair_reg    <= 1'b0;
        end else begin
            field_reg   <= field_next;
            stopped_reg <= stopped_next;
            ptr_reg     <= ptr_next;
            if (spin_start) begin
                all_reg  <= 1'b0;
                pair_reg <= 1'b0;
            end else if (last_stop) begin
                all_reg  <= all_next;
                pair_reg <= pair_next;
            end
        end
    end

    assign spin_value   = field_reg;
    assign reel_stopped = stopped_reg;
    assign all_match    = all_reg;
    assign pair_match   = pair_reg;

endmodule

// File: tb/tb_reel_spin_controller.sv
// Directed bench for reel_spin_controller: 3 reels, PRESCALE=1, DEBOUNCE=4.
module tb_reel_spin_controller;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        start;
    logic        stop_key;
    logic [11:0] spin_value;
    logic [2:0]  reel_stopped;
    logic        busy, done, all_match, pair_match;

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_cnt [3];

    reel_spin_controller #(
        .NUM_REELS(3), .DIGIT_W(4), .SYMBOLS(16), .PRESCALE(1), .DEBOUNCE(4)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .stop_key    (stop_key),
        .spin_value  (spin_value),
        .reel_stopped(reel_stopped),
        .busy        (busy),
        .done        (done),
        .all_match   (all_match),
        .pair_match  (pair_match)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference reel counters: advance by 2i+1 (mod 16) every clock
    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) m_cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 3; i++) m_cnt[i] <= m_cnt[i] + 4'(2 * i + 1);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge; presses so the reel freezes at value v
    task automatic press_reel(input int idx, input logic [3:0] v);
        int guard = 0;
        while (4'(int'(m_cnt[idx]) + 6 * (2 * idx + 1)) != v && guard < 32) begin
            @(posedge CLOCK_50); #1;
            guard++;
        end
        stop_key = 1'b0;
        repeat (6) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_value("pre_stop", 32'(reel_stopped[idx]), 32'd0);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_value("stop_bit", 32'(reel_stopped[idx]), 32'd1);
        check_value("stop_val", 32'(spin_value[idx*4 +: 4]), 32'(v));
        $display("press reel=%0d value=%0h stopped=%b", idx, spin_value[idx*4 +: 4], reel_stopped);
        stop_key = 1'b1;
    endtask

    task automatic gap();
        repeat (8) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_v;
        reset = 1'b1; start = 1'b0; stop_key = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_value("rst_value", 32'(spin_value), 32'd0);
        check_value("rst_stopped", 32'(reel_stopped), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_all", 32'(all_match), 32'd0);
        check_value("rst_pair", 32'(pair_match), 32'd0);
        reset = 1'b0;

        // Spin 1: start sampled on the third edge shows counters 3,9,15 live
        @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
        pulse_start();
        @(posedge CLOCK_50); #1;
        check_value("live_3cyc", 32'(spin_value), 32'h0F93);
        check_value("spin_busy", 32'(busy), 32'd1);
        $display("spin1 start value=%h", spin_value);
        press_reel(2, 4'h7);
        check_value("stopped_100", 32'(reel_stopped), 32'b100);
        gap();
        press_reel(1, 4'h7);
        check_value("stopped_110", 32'(reel_stopped), 32'b110);
        gap();
        press_reel(0, 4'h7);
        check_value("s1_done", 32'(done), 32'd1);
        check_value("s1_busy_res", 32'(busy), 32'd1);
        check_value("s1_all", 32'(all_match), 32'd1);
        check_value("s1_pair", 32'(pair_match), 32'd1);
        check_value("s1_value", 32'(spin_value), 32'h0777);
        check_value("s1_stopped", 32'(reel_stopped), 32'b111);
        @(posedge CLOCK_50); @(negedge CLOCK_50);
        check_value("s1_done_end", 32'(done), 32'd0);
        check_value("s1_busy_end", 32'(busy), 32'd0);
        check_value("s1_all_hold", 32'(all_match), 32'd1);
        $display("spin1 result value=%h all=%b pair=%b", spin_value, all_match, pair_match);
        stop_key = 1'b1;
        gap();

        // Press while idle must not disturb anything
        stop_key = 1'b0;
        repeat (10) @(posedge CLOCK_50);
        stop_key = 1'b1;
        gap();
        check_value("idle_value", 32'(spin_value), 32'h0777);
        check_value("idle_stopped", 32'(reel_stopped), 32'b111);
        check_value("idle_busy", 32'(busy), 32'd0);
        $display("idle press value=%h", spin_value);

        // Spin 2: live tracking, start ignored in SPIN and RESULT, values 7,7,2
        pulse_start();
        @(posedge CLOCK_50); @(negedge CLOCK_50);
        check_value("s2_live0", 32'(spin_value[3:0]), 32'(4'(m_cnt[0] - 4'd1)));
        check_value("s2_live1", 32'(spin_value[7:4]), 32'(4'(m_cnt[1] - 4'd3)));
        check_value("s2_clr_stopped", 32'(reel_stopped), 32'd0);
        check_value("s2_clr_all", 32'(all_match), 32'd0);
        @(posedge CLOCK_50); #1;
        press_reel(2, 4'h7);
        gap();
        pulse_start();
        check_value("s2_start_ign", 32'(reel_stopped), 32'b100);
        check_value("s2_busy", 32'(busy), 32'd1);
        press_reel(1, 4'h7);
        gap();
        press_reel(0, 4'h2);
        check_value("s2_done", 32'(done), 32'd1);
        check_value("s2_all", 32'(all_match), 32'd0);
        check_value("s2_pair", 32'(pair_match), 32'd1);
        check_value("s2_value", 32'(spin_value), 32'h0772);
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        @(negedge CLOCK_50);
        check_value("s2_res_start", 32'(busy), 32'd0);
        check_value("s2_res_stopped", 32'(reel_stopped), 32'b111);
        check_value("s2_done_end", 32'(done), 32'd0);
        $display("spin2 result value=%h all=%b pair=%b", spin_value, all_match, pair_match);
        gap();

        // Spin 3: bouncing key gives a single event 6 cycles after settling
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            stop_key = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            @(posedge CLOCK_50); #1;
        end
        check_value("bounce_early", 32'(reel_stopped), 32'd0);
        exp_v = 4'(int'(m_cnt[2]) + 30);
        stop_key = 1'b0;
        repeat (6) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_value("bounce_pre", 32'(reel_stopped), 32'd0);
        @(posedge CLOCK_50); @(negedge CLOCK_50);
        check_value("bounce_stop", 32'(reel_stopped), 32'b100);
        check_value("bounce_val", 32'(spin_value[11:8]), 32'(exp_v));
        repeat (6) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_value("bounce_once", 32'(reel_stopped), 32'b100);
        $display("bounce press value=%h stopped=%b", spin_value, reel_stopped);
        stop_key = 1'b1;
        gap();
        press_reel(1, 4'h5);

        // Asynchronous reset mid-spin
        #2 reset = 1'b1;
        #1;
        check_value("arst_value", 32'(spin_value), 32'd0);
        check_value("arst_stopped", 32'(reel_stopped), 32'd0);
        check_value("arst_busy", 32'(busy), 32'd0);
        check_value("arst_pair", 32'(pair_match), 32'd0);
        $display("reset mid-spin value=%h busy=%b", spin_value, busy);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(posedge CLOCK_50); #1;

        // Spin 4: full three-stop spin after reset, all distinct
        pulse_start();
        check_value("s4_busy", 32'(busy), 32'd1);
        @(posedge CLOCK_50); #1;
        press_reel(2, 4'h3);
        gap();
        press_reel(1, 4'h2);
        gap();
        press_reel(0, 4'h1);
        check_value("s4_done", 32'(done), 32'd1);
        check_value("s4_value", 32'(spin_value), 32'h0321);
        check_value("s4_stopped", 32'(reel_stopped), 32'b111);
        check_value("s4_all", 32'(all_match), 32'd0);
        check_value("s4_pair", 32'(pair_match), 32'd0);
        @(posedge CLOCK_50); @(negedge CLOCK_50);
        check_value("s4_done_end", 32'(done), 32'd0);
        check_value("s4_busy_end", 32'(busy), 32'd0);
        $display("spin4 result value=%h all=%b pair=%b", spin_value, all_match, pair_match);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
